// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: control, instruction-memory port and decode-side port.
// The fetch_queue connects through the master modport; its environment uses slave.
interface fetch_queue_if;
   logic        halt_in;
   logic        redirect_in;
   logic [31:0] redirect_addr_in;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_valid_in;
   logic [31:0] mem_data_in;
   logic        ins_valid_out;
   logic [31:0] ins_data_out;
   logic [31:0] ins_pc_out;
   logic        ins_ready_in;
   logic [3:0]  count_out;

   modport master (
      input  halt_in, redirect_in, redirect_addr_in, mem_valid_in, mem_data_in, ins_ready_in,
      output mem_req_out, mem_addr_out, ins_valid_out, ins_data_out, ins_pc_out, count_out
   );

   modport slave (
      output halt_in, redirect_in, redirect_addr_in, mem_valid_in, mem_data_in, ins_ready_in,
      input  mem_req_out, mem_addr_out, ins_valid_out, ins_data_out, ins_pc_out, count_out
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: single-outstanding memory fetcher feeding a DEPTH-entry FIFO
// of {pc, word} pairs to decode, with redirect flush and in-flight response dropping.
module fetch_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic          clock_in,
   input  logic          reset_in,
   fetch_queue_if.master bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   after_pop;
   logic [CNT_W-1:0]   cnt_after;
   logic               push;
   logic               pop;

   logic               mem_req_q;
   logic               ins_valid_q;
   logic [31:0]        ins_data_q, ins_data_d;
   logic [31:0]        ins_pc_q, ins_pc_d;

   logic [31:0]        q_data [DEPTH];
   logic [31:0]        q_pc   [DEPTH];

   logic [1:0]         unused_addr_bits;
   assign unused_addr_bits = bus.redirect_addr_in[1:0];

   // Redirect suppresses both queue operations in the cycle it is seen.
   assign pop  = (count_q != '0) && bus.ins_ready_in && !bus.redirect_in;
   assign push = (state_q == REQ) && bus.mem_valid_in && !bus.redirect_in;

   assign after_pop = count_q - CNT_W'(pop);
   assign cnt_after = after_pop + CNT_W'(push);

   // State register and queue bookkeeping.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_ADDR;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         mem_req_q   <= 1'b0;
         ins_valid_q <= 1'b0;
         ins_data_q  <= '0;
         ins_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         mem_req_q   <= (state_d == REQ);
         ins_valid_q <= (count_d != '0);
         ins_data_q  <= ins_data_d;
         ins_pc_q    <= ins_pc_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by count and pointers.
   always_ff @(posedge clock_in) begin
      if (push) begin
         q_data[wr_ptr_q] <= bus.mem_data_in;
         q_pc[wr_ptr_q]   <= fetch_pc_q;
      end
   end

   // Next-state, pointer/count update and next head value.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ins_data_d = '0;
      ins_pc_d   = '0;

      if (bus.redirect_in) begin
         fetch_pc_d = {bus.redirect_addr_in[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         count_d = cnt_after;
      end

      unique case (state_q)
         IDLE: begin
            if (!bus.halt_in && !bus.redirect_in && (count_q < CNT_W'(DEPTH))) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.mem_valid_in) begin
               if (bus.redirect_in) begin
                  state_d = IDLE;
               end else if (!bus.halt_in && (cnt_after < CNT_W'(DEPTH))) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.redirect_in) begin
               state_d = DROP;
            end
         end
         DROP: begin
            // The stale response retires the outstanding request even alongside a redirect.
            if (bus.mem_valid_in) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A word pushed into an otherwise-empty queue becomes the head directly.
      if (count_d != '0) begin
         if (push && (after_pop == '0)) begin
            ins_data_d = bus.mem_data_in;
            ins_pc_d   = fetch_pc_q;
         end else begin
            ins_data_d = q_data[rd_ptr_d];
            ins_pc_d   = q_pc[rd_ptr_d];
         end
      end
   end

   assign bus.mem_req_out   = mem_req_q;
   assign bus.mem_addr_out  = fetch_pc_q;
   assign bus.ins_valid_out = ins_valid_q;
   assign bus.ins_data_out  = ins_data_q;
   assign bus.ins_pc_out    = ins_pc_q;
   assign bus.count_out     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, reset/wrap sequences,
// randomised traffic, and a scoreboard of expected {pc, word} pairs.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   errors = 0;
   int   checks = 0;

   fetch_queue_if ifa ();
   fetch_queue_if ifb ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut_a (
      .clock_in (clk),
      .reset_in (rst_a),
      .bus      (ifa.master)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFF8)) dut_b (
      .clock_in (clk),
      .reset_in (rst_b),
      .bus      (ifb.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   assign ifa.mem_data_in = memfn(ifa.mem_addr_out);
   assign ifb.mem_data_in = memfn(ifb.mem_addr_out);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard for dut_a: words accepted from memory, popped when decode consumes.
   logic [63:0] sb [$];
   logic [31:0] exp_pc;
   logic [63:0] head;

   always @(negedge clk) begin
      if (!rst_a) begin
         sb.delete();
         exp_pc = 32'h0;
      end else begin
         chk("sb_count", 32'(ifa.count_out), 32'(sb.size()));
         chk("sb_valid", 32'(ifa.ins_valid_out), 32'(sb.size() != 0));
         if (sb.size() == 0) begin
            chk("empty_data", ifa.ins_data_out, 32'h0);
            chk("empty_pc", ifa.ins_pc_out, 32'h0);
         end
         if (ifa.mem_req_out) begin
            chk("req_addr", ifa.mem_addr_out, exp_pc);
            chk("no_push_full", 32'(ifa.count_out < 4'(DEPTH)), 32'd1);
         end
         if (ifa.redirect_in) begin
            sb.delete();
            exp_pc = {ifa.redirect_addr_in[31:2], 2'b00};
         end else begin
            if (ifa.ins_valid_out && ifa.ins_ready_in) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL pop_empty: got pc %h expected no entry", ifa.ins_pc_out);
               end else begin
                  head = sb.pop_front();
                  if (ifa.ins_pc_out !== head[63:32] || ifa.ins_data_out !== head[31:0]) begin
                     errors++;
                     $display("FAIL head: got %h/%h expected %h/%h", ifa.ins_pc_out,
                              ifa.ins_data_out, head[63:32], head[31:0]);
                  end
               end
            end
            if (ifa.mem_req_out && ifa.mem_valid_in) begin
               sb.push_back({exp_pc, memfn(exp_pc)});
               exp_pc += 32'd4;
            end
         end
      end
   end

   // Delivery log for dut_b (wrap test).
   logic [31:0] b_pcs  [$];
   logic [31:0] b_data [$];

   always @(negedge clk) begin
      if (rst_b && ifb.ins_valid_out && ifb.ins_ready_in && !ifb.redirect_in) begin
         b_pcs.push_back(ifb.ins_pc_out);
         b_data.push_back(ifb.ins_data_out);
      end
   end

   typedef struct {
      logic        halt;
      logic        redir;
      logic [31:0] raddr;
      logic        mv;
      logic        rdy;
      logic        req;
      logic [3:0]  cnt;
      logic [31:0] addr;
   } vec_t;

   localparam int NV = 22;
   vec_t vec [NV];
   logic [31:0] bexp [3];

   initial begin
      //          halt redir raddr         mv rdy  req cnt   addr
      vec[0]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd0, 32'h0000};
      vec[1]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 4'd1, 32'h0004};
      vec[2]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 4'd2, 32'h0008};
      vec[3]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 4'd3, 32'h000C};
      vec[4]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 4'd4, 32'h0010};
      vec[5]  = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 4'd4, 32'h0010};
      vec[6]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 4'd3, 32'h0010};
      vec[7]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd3, 32'h0010};
      vec[8]  = '{1'b0, 1'b1, 32'h1003,   1'b0, 1'b0, 1'b0, 4'd0, 32'h1000};
      vec[9]  = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 4'd0, 32'h1000};
      vec[10] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 4'd0, 32'h1000};
      vec[11] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd0, 32'h1000};
      vec[12] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 4'd1, 32'h1004};
      vec[13] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 4'd1, 32'h1008};
      vec[14] = '{1'b0, 1'b1, 32'h2000,   1'b1, 1'b1, 1'b0, 4'd0, 32'h2000};
      vec[15] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd0, 32'h2000};
      vec[16] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd0, 32'h2000};
      vec[17] = '{1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 1'b0, 4'd1, 32'h2004};
      vec[18] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 4'd1, 32'h2004};
      vec[19] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 4'd0, 32'h2004};
      vec[20] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 4'd0, 32'h2004};
      vec[21] = '{1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 4'd1, 32'h2008};
      bexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

      ifa.halt_in = 1'b0; ifa.redirect_in = 1'b0; ifa.redirect_addr_in = 32'h0;
      ifa.mem_valid_in = 1'b0; ifa.ins_ready_in = 1'b0;
      ifb.halt_in = 1'b0; ifb.redirect_in = 1'b0; ifb.redirect_addr_in = 32'h0;
      ifb.mem_valid_in = 1'b0; ifb.ins_ready_in = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(ifa.mem_req_out), 32'd0);
      chk("rst_addr", ifa.mem_addr_out, 32'h0);
      chk("rst_valid", 32'(ifa.ins_valid_out), 32'd0);
      chk("rst_data", ifa.ins_data_out, 32'h0);
      chk("rst_pc", ifa.ins_pc_out, 32'h0);
      chk("rst_count", 32'(ifa.count_out), 32'd0);
      chk("rst_b_addr", ifb.mem_addr_out, 32'hFFFF_FFF8);
      rst_a = 1'b1;

      for (int i = 0; i < NV; i++) begin
         ifa.halt_in          = vec[i].halt;
         ifa.redirect_in      = vec[i].redir;
         ifa.redirect_addr_in = vec[i].raddr;
         ifa.mem_valid_in     = vec[i].mv;
         ifa.ins_ready_in     = vec[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_req", i), 32'(ifa.mem_req_out), 32'(vec[i].req));
         chk($sformatf("v%0d_cnt", i), 32'(ifa.count_out), 32'(vec[i].cnt));
         chk($sformatf("v%0d_addr", i), ifa.mem_addr_out, vec[i].addr);
      end

      // Reset asserted mid-request; a late response after release must be ignored.
      ifa.mem_valid_in = 1'b0; ifa.ins_ready_in = 1'b0;
      #2 rst_a = 1'b0;
      #1;
      chk("mid_rst_req", 32'(ifa.mem_req_out), 32'd0);
      chk("mid_rst_count", 32'(ifa.count_out), 32'd0);
      chk("mid_rst_valid", 32'(ifa.ins_valid_out), 32'd0);
      chk("mid_rst_addr", ifa.mem_addr_out, 32'h0);
      chk("mid_rst_data", ifa.ins_data_out, 32'h0);
      @(posedge clk);
      #1;
      ifa.mem_valid_in = 1'b1;
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      chk("late_valid_req", 32'(ifa.mem_req_out), 32'd1);
      chk("late_valid_cnt", 32'(ifa.count_out), 32'd0);
      ifa.mem_valid_in = 1'b0;

      // Randomised traffic, checked by the scoreboard.
      for (int c = 0; c < 400; c++) begin
         ifa.halt_in          = ($urandom_range(7) == 0);
         ifa.redirect_in      = ($urandom_range(19) == 0);
         ifa.redirect_addr_in = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                         : $urandom;
         ifa.mem_valid_in     = ($urandom_range(2) != 0);
         ifa.ins_ready_in     = ($urandom_range(1) == 0);
         @(posedge clk);
         #1;
      end
      ifa.halt_in = 1'b0; ifa.redirect_in = 1'b0; ifa.mem_valid_in = 1'b0; ifa.ins_ready_in = 1'b0;

      // Fetch PC wrap with continuous ready on dut_b.
      ifb.mem_valid_in = 1'b1;
      ifb.ins_ready_in = 1'b1;
      rst_b = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("wrap_delivered", 32'(b_pcs.size() >= 3), 32'd1);
      for (int k = 0; k < 3; k++) begin
         if (k < b_pcs.size()) begin
            chk($sformatf("wrap_pc%0d", k), b_pcs[k], bexp[k]);
            chk($sformatf("wrap_data%0d", k), b_data[k], memfn(bexp[k]));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
